lcm_cal: RTL
============

LCM_CAL -- requirements
Module: lcm_cal

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand width in bits.
REQ-002 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  an operand triple is presented.
REQ-005 in_ready  output  1  the block can accept a triple.
REQ-006 a  input  W  first operand.
REQ-007 b  input  W  second operand.
REQ-008 g  input  W  GCD of a and b, produced by the upstream GCD calculator.
REQ-009 out_valid  output  1  the result is available.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 lcm  output  2W  least common multiple, a*b/g.
REQ-012 err  output  1  g is inconsistent with a and b.

Function
REQ-013 The block SHALL accept a triple on a rising edge where in_valid=1 and in_ready=1, and SHALL register a, b, g and the full 2W-bit product a*b.
REQ-014 States SHALL be IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 When IDLE accepts a triple with a==0 or b==0, the next state SHALL be DONE with lcm=0 and err=0.
REQ-016 When IDLE accepts a triple with a!=0, b!=0 and g==0, the next state SHALL be DONE with lcm=0 and err=1.
REQ-017 In all other accept cases, the next state SHALL be CALC with the step counter at 0 and the remainder at 0.
REQ-018 CALC SHALL perform a restoring division of the registered product by g, one quotient bit per cycle, MSB first, for exactly 2W cycles, then enter DONE.
REQ-019 For the default W, a non-short-path accept SHALL raise out_valid 2W+1 = 9 rising edges after the accept edge; the short paths SHALL raise it 1 edge after the accept edge.
REQ-020 On entering DONE from CALC, lcm SHALL equal the quotient, and err SHALL be 1 if and only if the final remainder is non-zero.
REQ-021 The remainder register SHALL be W+1 bits wide so that the trial subtraction never overflows.
REQ-022 lcm and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 DONE SHALL move to IDLE on an edge where out_ready=1.
REQ-024 A new triple SHALL NOT be accepted on the same edge as the result handoff; the earliest new accept is the following edge.
REQ-025 in_valid SHALL be ignored in CALC and DONE, and out_ready SHALL be ignored outside DONE.
REQ-026 lcm and err SHALL keep their last DONE values in IDLE and CALC, and SHALL be qualified only by out_valid.

Reset
REQ-027 While rst=1, the block SHALL force state=IDLE, in_ready=1, out_valid=0, lcm=0, err=0, counter=0, quotient=0 and remainder=0, independent of clk.
REQ-028 Asserting rst during CALC or DONE SHALL abandon the operation with no out_valid pulse.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package gcd_pkg SHALL hold the W default and the state enumeration (IDLE, CALC, DONE) for reuse by the GCD calculator stages.
REQ-031 The single division step SHALL be a combinational sub-module div_step (shift in the next product bit, trial subtract g, select the result, emit the quotient bit); the FSM, counter and registers SHALL remain in lcm_cal.

Verification
REQ-032 a=12, b=8, g=4 -> out_valid on edge 9 after accept, lcm=24, err=0.
REQ-033 a=15, b=14, g=1 -> lcm=210, err=0, taking the full 8 CALC cycles.
REQ-034 a=0, b=5, g=5 -> out_valid 1 edge after accept, lcm=0, err=0; a=6, b=4, g=0 -> lcm=0, err=1.
REQ-035 a=6, b=4, g=5 (inconsistent) -> lcm=4, err=1.
REQ-036 Result 24 with out_ready held 0 for 5 cycles -> lcm, err and out_valid stable, in_valid ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-037 rst pulsed mid-CALC, between clock edges -> outputs reset immediately, no out_valid; the next triple 9, 6, 3 -> lcm=18.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types for the GCD/LCM calculator stages.
// Holds the default operand width and the FSM state encoding.
package gcd_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it fits.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   rem,
  input  logic         pbit,
  input  logic [W-1:0] g,
  output logic [W:0]   nrem,
  output logic         qbit
);

  logic [W:0] shifted;
  logic [W:0] dvsr;
  logic       ge;

  assign shifted = {rem[W-1:0], pbit};
  assign dvsr    = {1'b0, g};
  // a set top bit means the shifted value already exceeds any divisor
  assign ge      = rem[W] | (shifted >= dvsr);
  assign nrem    = ge ? shifted - dvsr : shifted;
  assign qbit    = ge;

endmodule

// File: rtl/lcm_cal.sv
// LCM from a GCD triple: registers a*b, then divides it by g
// one quotient bit per cycle; err flags a non-divisor g.
module lcm_cal
  import gcd_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   g,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] lcm,
  output logic           err
);

  localparam int CW = $clog2(2 * W);

  state_t         state;
  state_t         nxt;
  logic [2*W-1:0] prod;
  logic [2*W-2:0] quot;
  logic [W-1:0]   gr;
  logic [W:0]     rem;
  logic [W:0]     nrem;
  logic [CW-1:0]  cnt;
  logic           qbit;
  logic           acc;
  logic           zop;
  logic           short;
  logic           last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign acc       = in_valid & in_ready;
  assign zop       = (a == '0) || (b == '0);
  assign short     = zop || (g == '0);
  assign last      = (cnt == CW'(2 * W - 1));

  div_step #(
    .W(W)
  ) u_step (
    .rem (rem),
    .pbit(prod[2*W-1]),
    .g   (gr),
    .nrem(nrem),
    .qbit(qbit)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) nxt = short ? DONE : CALC;
      CALC: if (last) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      quot <= '0;
      gr   <= '0;
      rem  <= '0;
      cnt  <= '0;
      lcm  <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            prod <= (2 * W)'(a) * (2 * W)'(b);
            gr   <= g;
            quot <= '0;
            rem  <= '0;
            cnt  <= '0;
            if (short) begin
              lcm <= '0;
              err <= ~zop;
            end
          end
        end
        CALC: begin
          prod <= prod << 1;
          rem  <= nrem;
          quot <= {quot[2*W-3:0], qbit};
          cnt  <= cnt + CW'(1);
          // last step: the final quotient bit comes straight from div_step
          if (last) begin
            lcm <= {quot, qbit};
            err <= (nrem != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
